// File: rtl/stream_arb_2to1.sv
`default_nettype none
// ============================================================================
// Module   : stream_arb_2to1
// Brief    : Two-input valid/ready round-robin stream arbiter with a one-entry
//            registered output slot; out_sel drives a downstream mux_2to1 sel.
// Config   : define ARB_PKT_LOCK_EN for packet locking (default: beat-level RR)
// Revision : 1.0 - initial release
// ============================================================================
module stream_arb_2to1 #(
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in0_valid,
    output logic              in0_ready,
    input  logic [DATA_W-1:0] in0_data,
    input  logic              in0_last,
    input  logic              in1_valid,
    output logic              in1_ready,
    input  logic [DATA_W-1:0] in1_data,
    input  logic              in1_last,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_last,
    output logic              out_sel
);

`ifdef ARB_PKT_LOCK_EN
    localparam logic [1:0] c_IDLE  = 2'd0;
    localparam logic [1:0] c_LOCK0 = 2'd1;
    localparam logic [1:0] c_LOCK1 = 2'd2;

    logic [1:0]        r_state;
    logic [1:0]        w_state_nxt;
`endif

    logic              r_last_served;
    logic              r_out_valid;
    logic [DATA_W-1:0] r_out_data;
    logic              r_out_last;
    logic              r_out_sel;

    logic              w_last_served_nxt;
    logic              w_out_valid_nxt;
    logic [DATA_W-1:0] w_out_data_nxt;
    logic              w_out_last_nxt;
    logic              w_out_sel_nxt;

    logic              w_out_free;
    logic              w_grant;
    logic              w_winner;
    logic              w_acc;
    logic              w_acc_src;
    logic [DATA_W-1:0] w_acc_data;
    logic              w_acc_last;

    // A beat may enter the slot in the same cycle the held one leaves.
    assign w_out_free = !r_out_valid || out_ready;

    always_comb begin
        w_grant  = 1'b0;
        w_winner = 1'b0;
`ifdef ARB_PKT_LOCK_EN
        if (r_state == c_LOCK0) begin
            w_grant  = 1'b1;
            w_winner = 1'b0;
        end else if (r_state == c_LOCK1) begin
            w_grant  = 1'b1;
            w_winner = 1'b1;
        end else
`endif
        if (in0_valid && in1_valid) begin
            w_grant  = 1'b1;
            w_winner = !r_last_served;
        end else if (in0_valid) begin
            w_grant  = 1'b1;
            w_winner = 1'b0;
        end else if (in1_valid) begin
            w_grant  = 1'b1;
            w_winner = 1'b1;
        end
    end

    // rst_n gating keeps both readies low for the whole reset assertion.
    assign in0_ready = rst_n && w_out_free && w_grant && !w_winner;
    assign in1_ready = rst_n && w_out_free && w_grant &&  w_winner;

    assign w_acc      = (in0_valid && in0_ready) || (in1_valid && in1_ready);
    assign w_acc_src  = in1_ready;
    assign w_acc_data = w_acc_src ? in1_data : in0_data;
    assign w_acc_last = w_acc_src ? in1_last : in0_last;

    always_comb begin
        w_last_served_nxt = r_last_served;
        w_out_valid_nxt   = r_out_valid;
        w_out_data_nxt    = r_out_data;
        w_out_last_nxt    = r_out_last;
        w_out_sel_nxt     = r_out_sel;
`ifdef ARB_PKT_LOCK_EN
        w_state_nxt       = r_state;
`endif
        if (w_acc) begin
            w_out_valid_nxt = 1'b1;
            w_out_data_nxt  = w_acc_data;
            w_out_last_nxt  = w_acc_last;
            w_out_sel_nxt   = w_acc_src;
`ifdef ARB_PKT_LOCK_EN
            if (w_acc_last) begin
                w_last_served_nxt = w_acc_src;
                w_state_nxt       = c_IDLE;
            end else begin
                w_state_nxt = w_acc_src ? c_LOCK1 : c_LOCK0;
            end
`else
            w_last_served_nxt = w_acc_src;
`endif
        end else if (out_ready) begin
            // Data, last and sel keep their stale values once the slot drains.
            w_out_valid_nxt = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_last_served <= 1'b1;
            r_out_valid   <= 1'b0;
            r_out_data    <= '0;
            r_out_last    <= 1'b0;
            r_out_sel     <= 1'b0;
`ifdef ARB_PKT_LOCK_EN
            r_state       <= c_IDLE;
`endif
        end else begin
            r_last_served <= w_last_served_nxt;
            r_out_valid   <= w_out_valid_nxt;
            r_out_data    <= w_out_data_nxt;
            r_out_last    <= w_out_last_nxt;
            r_out_sel     <= w_out_sel_nxt;
`ifdef ARB_PKT_LOCK_EN
            r_state       <= w_state_nxt;
`endif
        end
    end

    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;
    assign out_last  = r_out_last;
    assign out_sel   = r_out_sel;

endmodule
`default_nettype wire

// File: tb/tb_stream_arb_2to1.sv
`default_nettype none
// ============================================================================
// Module   : tb_stream_arb_2to1
// Brief    : Self-checking bench for stream_arb_2to1: directed scenarios plus
//            random traffic against a queue-level reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_stream_arb_2to1;

`ifdef ARB_PKT_LOCK_EN
    localparam bit LOCK_EN = 1'b1;
`else
    localparam bit LOCK_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst_n;
    logic       in0_valid, in0_ready, in0_last;
    logic [7:0] in0_data;
    logic       in1_valid, in1_ready, in1_last;
    logic [7:0] in1_data;
    logic       out_valid, out_ready, out_last, out_sel;
    logic [7:0] out_data;

    int n_total = 0;
    int n_bad   = 0;

    // Reference model: the held slot, who was served last, and the locked source (-1 = none).
    bit       m_valid;
    bit [7:0] m_data;
    bit       m_last;
    bit       m_sel;
    bit       m_ls;
    int       m_lock;
    bit       acc0, acc1;

    logic [8:0] q0[$];
    logic [8:0] q1[$];
    logic [7:0] cap_data[$];
    logic       cap_sel[$];
    int         cap_cyc[$];

    logic [7:0] exp_d[5];
    logic       exp_s[5];

    stream_arb_2to1 #(.DATA_W(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in0_valid (in0_valid),
        .in0_ready (in0_ready),
        .in0_data  (in0_data),
        .in0_last  (in0_last),
        .in1_valid (in1_valid),
        .in1_ready (in1_ready),
        .in1_data  (in1_data),
        .in1_last  (in1_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_last  (out_last),
        .out_sel   (out_sel)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h expected=%0h at t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_valid = 1'b0; m_data = 8'h00; m_last = 1'b0; m_sel = 1'b0;
        m_ls    = 1'b1; m_lock = -1;
    endtask

    function automatic int pick();
        if (m_lock >= 0) return m_lock;
        if (in0_valid && in1_valid) return m_ls ? 0 : 1;
        if (in0_valid) return 0;
        if (in1_valid) return 1;
        return -1;
    endfunction

    // Called just after a falling edge with inputs settled; returns after the next falling edge.
    task automatic step(input int cyc);
        int w;
        bit free, e0, e1, src;
        #1;
        w    = pick();
        free = !m_valid || out_ready;
        e0   = rst_n && free && (w == 0);
        e1   = rst_n && free && (w == 1);
        check_val("in0_ready", 32'(in0_ready), 32'(e0));
        check_val("in1_ready", 32'(in1_ready), 32'(e1));
        acc0 = e0 && in0_valid;
        acc1 = e1 && in1_valid;
        @(posedge clk);
        if (!rst_n) begin
            model_reset();
        end else if (acc0 || acc1) begin
            src     = acc1;
            m_valid = 1'b1;
            m_data  = src ? in1_data : in0_data;
            m_last  = src ? in1_last : in0_last;
            m_sel   = src;
            if (LOCK_EN) begin
                if (m_last) begin
                    m_ls   = src;
                    m_lock = -1;
                end else begin
                    m_lock = src ? 1 : 0;
                end
            end else begin
                m_ls = src;
            end
        end else if (out_ready) begin
            m_valid = 1'b0;
        end
        #1;
        check_val("out_valid", 32'(out_valid), 32'(m_valid));
        check_val("out_data",  32'(out_data),  32'(m_data));
        check_val("out_last",  32'(out_last),  32'(m_last));
        check_val("out_sel",   32'(out_sel),   32'(m_sel));
        if (out_valid) begin
            cap_data.push_back(out_data);
            cap_sel.push_back(out_sel);
            cap_cyc.push_back(cyc);
        end
        @(negedge clk);
    endtask

    // Drives q0/q1 as two sources, popping beats as the model accepts them.
    task automatic run_pkts(input int cycles);
        cap_data.delete(); cap_sel.delete(); cap_cyc.delete();
        for (int c = 0; c < cycles; c++) begin
            in0_valid = (q0.size() != 0);
            in0_data  = in0_valid ? q0[0][7:0] : 8'h00;
            in0_last  = in0_valid ? q0[0][8]   : 1'b0;
            in1_valid = (q1.size() != 0);
            in1_data  = in1_valid ? q1[0][7:0] : 8'h00;
            in1_last  = in1_valid ? q1[0][8]   : 1'b0;
            step(c);
            if (acc0) void'(q0.pop_front());
            if (acc1) void'(q1.pop_front());
        end
        in0_valid = 1'b0;
        in1_valid = 1'b0;
    endtask

    initial begin
        model_reset();
        rst_n     = 1'b0;
        out_ready = 1'b1;
        in0_valid = 1'b1; in0_data = 8'hE0; in0_last = 1'b1;
        in1_valid = 1'b1; in1_data = 8'hE1; in1_last = 1'b1;
        @(negedge clk);

        // Reset held with both sources requesting.
        for (int i = 0; i < 3; i++) begin
            step(i);
            check_val("rst_out_sel", 32'(out_sel), 32'd0);
            check_val("rst_out_valid", 32'(out_valid), 32'd0);
        end
        rst_n = 1'b1;

        // Contention: 3-beat packet on source 0, 2-beat packet on source 1.
        q0 = '{9'h0A0, 9'h0A1, 9'h1A2};
        q1 = '{9'h0B0, 9'h1B1};
        if (LOCK_EN) begin
            exp_d = '{8'hA0, 8'hA1, 8'hA2, 8'hB0, 8'hB1};
            exp_s = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
        end else begin
            exp_d = '{8'hA0, 8'hB0, 8'hA1, 8'hB1, 8'hA2};
            exp_s = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
        end
        run_pkts(8);
        check_val("cont_count", 32'(cap_data.size()), 32'd5);
        for (int i = 0; i < 5 && i < cap_data.size(); i++) begin
            check_val("cont_data", 32'(cap_data[i]), 32'(exp_d[i]));
            check_val("cont_sel",  32'(cap_sel[i]),  32'(exp_s[i]));
        end
        if (cap_cyc.size() >= 5)
            check_val("cont_back_to_back", 32'(cap_cyc[4] - cap_cyc[0]), 32'd4);

        // Back-pressure on a held 0x5C beat.
        in0_valid = 1'b1; in0_data = 8'h5C; in0_last = 1'b1;
        step(0);
        out_ready = 1'b0;
        in0_data = 8'h11; in1_valid = 1'b1; in1_data = 8'h22; in1_last = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step(i);
            check_val("bp_data", 32'(out_data), 32'h5C);
            check_val("bp_sel",  32'(out_sel),  32'd0);
            check_val("bp_last", 32'(out_last), 32'd1);
        end
        out_ready = 1'b1;
        step(0);
        check_val("bp_next_data", 32'(out_data), 32'h22);
        check_val("bp_next_sel",  32'(out_sel),  32'd1);
        in0_valid = 1'b0; in1_valid = 1'b0;
        step(0);

`ifdef ARB_PKT_LOCK_EN
        // Source 1 holds the lock while source 0 waits.
        in1_valid = 1'b1; in1_data = 8'hB0; in1_last = 1'b0;
        step(0);
        in0_valid = 1'b1; in0_data = 8'hA0; in0_last = 1'b1;
        in1_data  = 8'hB1;
        #1 check_val("lock_excl0", 32'(in0_ready), 32'd0);
        step(0);
        in1_data = 8'hB2; in1_last = 1'b1;
        #1 check_val("lock_excl1", 32'(in0_ready), 32'd0);
        step(0);
        in1_valid = 1'b0;
        #1 check_val("lock_release", 32'(in0_ready), 32'd1);
        step(0);
        in0_valid = 1'b0;
        step(0);
`endif

        // Reset in the middle of a packet from source 0 with the slot occupied.
        in0_valid = 1'b1; in0_data = 8'h70; in0_last = 1'b0;
        step(0);
        out_ready = 1'b0; in0_valid = 1'b0;
        rst_n = 1'b0;
        model_reset();
        #1 check_val("midrst_valid", 32'(out_valid), 32'd0);
        step(0);
        rst_n = 1'b1; out_ready = 1'b1;
        in1_valid = 1'b1; in1_data = 8'h71; in1_last = 1'b1;
        #1 check_val("midrst_in1_ready", 32'(in1_ready), 32'd1);
        step(0);
        check_val("midrst_sel", 32'(out_sel), 32'd1);
        in1_valid = 1'b0;

        // Random traffic with occasional asynchronous reset.
        for (int i = 0; i < 400; i++) begin
            rst_n = ($urandom_range(0, 99) != 0);
            if (!rst_n) model_reset();
            in0_valid = ($urandom_range(0, 9) < 6);
            in0_data  = 8'($urandom);
            in0_last  = ($urandom_range(0, 2) == 0);
            in1_valid = ($urandom_range(0, 9) < 6);
            in1_data  = 8'($urandom);
            in1_last  = ($urandom_range(0, 2) == 0);
            out_ready = ($urandom_range(0, 3) != 0);
            step(i);
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/stream_arb_2to1.md
# stream_arb_2to1

- Two-input valid/ready stream arbiter with a one-entry registered output slot.
- Picks one of two upstream packet streams with round-robin priority, registers the accepted beat, and presents it downstream.
- Exports `out_sel` to say which source the held beat came from.
- Sits directly upstream of `mux_2to1` and drives its `sel`.

## Interface

Parameters:
- `DATA_W`, default 8: width of each data beat.

Ports:
- `clk`, input, 1: single clock; all state updates on the rising edge.
- `rst_n`, input, 1: asynchronous, active-low reset.
- `in0_valid`, input, 1: source 0 beat valid.
- `in0_ready`, output, 1: source 0 beat accepted this cycle (when `in0_valid` is also high).
- `in0_data`, input, `DATA_W`: source 0 beat data.
- `in0_last`, input, 1: source 0 final beat of packet.
- `in1_valid`, `in1_ready`, `in1_data`, `in1_last`: same as source 0, for source 1.
- `out_valid`, output, 1: output slot holds a beat.
- `out_ready`, input, 1: downstream accepts the beat.
- `out_data`, output, `DATA_W`: held beat data.
- `out_last`, output, 1: held beat is the last beat of its packet.
- `out_sel`, output, 1: source index of the held beat (0 or 1); feeds `mux_2to1` `sel`.

## Operation

- Registers:
  - `state` ∈ {IDLE, LOCK0, LOCK1}
  - `last_served` (resets to 1, so source 0 wins first contention)
  - output slot: `out_valid`, `out_data`, `out_last`, `out_sel`
- `out_free` = !out_valid || out_ready. A beat may enter the slot in the same cycle the held one leaves.
- Winner in IDLE:
  - both valid: winner = !last_served;
  - one valid: that source;
  - none valid: no grant.
- Winner in LOCKx is source x only. The other source's ready stays 0 even if it is valid.
- `inX_ready` = (winner == X) && out_free. Ready is combinational from the valids, `state` and `out_ready`.
- Ready is never asserted to a non-winner. At most one `inX_ready` is high per cycle.
- On acceptance of a beat from X:
  - slot loads data, last and sel=X; `out_valid`=1;
  - if the beat is last: `last_served`=X, `state`=IDLE;
  - else: `state`=LOCKX.
- When the slot empties (out_ready && !accept), `out_valid`=0. Data, last and sel hold their stale values.
- Held beat stability: while `out_valid && !out_ready`, `out_data`, `out_last` and `out_sel` must not change.
- Reset mid-packet: the held beat is dropped, `state`=IDLE and the lock is released. A partial packet is the upstream's responsibility.

## Timing

- Reset values:
  - `out_valid`=0, `out_data`=0, `out_last`=0, `out_sel`=0
  - `state`=IDLE, `last_served`=1
  - `in0_ready`=0, `in1_ready`=0 while `rst_n` is low
- Latency: a beat accepted at edge N appears on `out_*` after edge N; it is visible in cycle N+1.
- Throughput: one beat per cycle with `out_ready` held at 1, including back-to-back packets from alternating sources. No idle cycle is inserted between packets.
- Back-pressure: `out_ready`=0 with `out_valid`=1 forces both readies to 0 in the same cycle.
- Switching sources: a packet's last beat and the other source's first beat may be accepted on consecutive edges.
- Arbitration sees the updated `state` and `last_served` one cycle after the last beat is accepted.

## Configuration

- Macro `ARB_PKT_LOCK_EN`.
- Defined: packet locking as described; LOCK0/LOCK1 are used; `last_served` updates only on last beats.
- Undefined:
  - `state` stays IDLE and every beat is arbitrated independently;
  - `last_served` updates on every accepted beat, giving beat-level round-robin;
  - `inX_last` is only carried through to `out_last`.

## Test plan

- **Reset.** Hold `rst_n`=0 for 3 cycles with both sources valid. Required: `out_valid`=0, `out_sel`=0, both readies 0. After release, the first accepted beat is from source 0.
- **Contention, lock on.** Source 0 sends a 3-beat packet (0xA0, 0xA1, 0xA2 last); source 1 sends 2 beats (0xB0, 0xB1 last); both valid from the same cycle; `out_ready`=1. Required output order: A0, A1, A2, B0, B1 on consecutive cycles. `out_sel` reads 0,0,0,1,1.
- **Back-pressure.** Hold `out_ready`=0 for 4 cycles with 0x5C held. Required: `out_data`=0x5C, `out_last` and `out_sel` stable, both readies 0. When `out_ready` returns to 1, the next beat appears the following cycle.
- **Lock excludes other source.** Source 1 is mid-packet (`state`=LOCK1) while source 0 is valid. Required: `in0_ready`=0 until source 1's last beat is accepted; source 0 is granted on the next cycle.
- **Lock off** (`ARB_PKT_LOCK_EN` undefined). Repeat the contention scenario. Required output order: A0, B0, A1, B1, A2, with `out_sel` alternating 0,1,0,1,0.
- **Reset mid-packet.** Assert `rst_n`=0 for 1 cycle during LOCK0 with `out_valid`=1. Required: `out_valid`=0 immediately, `state`=IDLE. With only source 1 valid afterwards, source 1 is accepted on the first edge after reset release.
